lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit controller between the core's execute stage and the data memory port. It accepts one load or store per handshake and drives a single-outstanding request/ack memory transaction with per-lane byte enables and lane-replicated store data. It then returns the load result, right-aligned and sign- or zero-extended by funct3. Malformed accesses and memory timeouts are reported as errors.

## Interface
- WIDTH, 32: data width; only 32 is supported.
- ADDR_W, 32: address width.
- TIMEOUT_CYC, 16: maximum cycles `mem_req` stays high without `mem_ack`; legal range 1–255.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I size/sign code.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  WIDTH  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  WIDTH  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualifies `rsp_valid`; access failed.
- mem_req  out  1  memory request; held until ack or timeout.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  word-aligned address: `{req_addr[ADDR_W-1:2], 2'b00}`.
- mem_be  out  4  byte-lane enables; driven for loads and stores.
- mem_wdata  out  WIDTH  lane-replicated store data.
- mem_ack  in  1  memory completion.
- mem_rdata  in  WIDTH  read word; valid when `mem_ack` is high.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - `req_valid & req_ready` captures we, funct3, addr and wdata into registers.
  - Legal access → ACCESS.
  - Illegal funct3 or (with macro) misaligned → RESP with error; no memory access.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Every other code is illegal.
- ACCESS:
  - `mem_req` = 1; mem outputs are driven from the captured registers.
  - `mem_ack` → latch data, → RESP.
  - Counter reaches TIMEOUT_CYC → RESP with error.
- RESP: `rsp_valid` = 1 for exactly one cycle, then → IDLE.
- Lane rules, with `off = addr[1:0]`:
  - Byte: `mem_be = 4'b0001 << off`; `mem_wdata = {4{wdata[7:0]}}`.
  - Half: `mem_be = 4'b0011 << {off[1],1'b0}`; `mem_wdata = {2{wdata[15:0]}}`.
  - Word: `mem_be = 4'b1111`; `mem_wdata = wdata`.
- Load data:
  - Shift `mem_rdata` right by `off*8` (half uses `{off[1],1'b0}*8`).
  - Then extend: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word unchanged.
- Boundaries:
  - `mem_ack` in the same cycle the timeout expires: ack wins, no error.
  - `mem_ack` while not in ACCESS is ignored.
  - `req_valid` outside IDLE is ignored; the core must hold it.

## Timing
- Request accepted in cycle 0.
- `mem_req` is high from cycle 1.
- An ack in cycle k gives `rsp_valid` in cycle k+1; the minimum is cycle 2 with a same-cycle ack.
- An error without memory access gives `rsp_valid` in cycle 1.
- Back-to-back throughput: one request per 3 cycles minimum.
- Reset values:
  - `req_ready` = 1 (IDLE).
  - All other outputs 0; all registers 0.
- Asserting `rst` in any state:
  - `mem_req` drops immediately (asynchronous); the pending response is discarded.
  - After release the FSM is in IDLE.

## Configuration
- MISALIGN_TRAP_EN, defined: a half access with `off[0] = 1`, or a word access with `off != 0`, returns `rsp_err = 1` in cycle 1 and issues no `mem_req`.
- MISALIGN_TRAP_EN, undefined: the same accesses proceed with offset bits forced aligned.
  - Half uses `{off[1],1'b0}`; word uses 0.
  - No error is raised.

## Structure
- `lsu_pkg` holds:
  - The FSM state enum.
  - funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW).
  - The `funct3_legal(we, f3)` function.
- Sub-module `load_align`: combinational offset shift plus sign/zero extension, instantiated once inside `lsu_ctrl`.
- All sequencing, timeout counting and response generation stay in `lsu_ctrl`.

## Test plan
- LB, addr 0x103, `mem_rdata` 0x80FF1234 → `mem_addr` 0x100, `mem_be` 1000, `rsp_rdata` 0xFFFFFF80, `rsp_err` 0.
- LHU, addr 0x102, `mem_rdata` 0x80FF1234 → `mem_be` 1100, `rsp_rdata` 0x000080FF.
- SB, addr 0x201, wdata 0x000000AB, ack in cycle 3 → `mem_we` 1, `mem_be` 0010, `mem_wdata` 0xABABABAB, `rsp_valid` in cycle 4, `rsp_rdata` 0.
- LW, addr 0x101:
  - MISALIGN_TRAP_EN defined → `rsp_err` 1 in cycle 1, `mem_req` never asserted.
  - Undefined → `mem_addr` 0x100, `mem_be` 1111.
- TIMEOUT_CYC = 4, no ack → `mem_req` high for exactly 4 cycles, then `rsp_valid` = 1 with `rsp_err` = 1.
  - Repeat with ack in the 4th cycle → no error.
- `rst` pulsed during ACCESS → `mem_req` = 0 immediately, no `rsp_valid`, `req_ready` = 1 after release.
- Illegal funct3 011 (load) → `rsp_err` 1 in cycle 1, no `mem_req`.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit controller.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // Wide enough for the largest supported timeout (255).
  localparam int unsigned CNT_W = 8;

  // True when funct3 names a supported access for the given direction.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 == SB) || (f3 == SH) || (f3 == SW);
    end
    return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
  endfunction

endpackage

// File: rtl/lsu_ctrl_load_align.sv
// Load data alignment: shifts the selected lane down and sign/zero extends it.
module load_align
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rdata,
  input  logic [2:0]       funct3,
  input  logic [1:0]       off,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] shifted;

  // Offset is already forced aligned for halves and words by the caller.
  always_comb begin
    shifted = rdata >> {off, 3'b000};
    data    = '0;
    case (funct3)
      LB:      data = {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
      LH:      data = {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
      LW:      data = shifted;
      LBU:     data = {{(WIDTH-8){1'b0}}, shifted[7:0]};
      LHU:     data = {{(WIDTH-16){1'b0}}, shifted[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: single-outstanding memory access with lane
// enables, replicated store data, aligned/extended load return and timeout.
// Optional macro MISALIGN_TRAP_EN: misaligned half/word accesses return an
// error without touching memory; otherwise their offsets are forced aligned.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic              mem_ack,
  input  logic [WIDTH-1:0]  mem_rdata
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              capture_c, done_ok_c, done_err_c, misalign_c;
  logic [1:0]        eff_off_c;
  logic [3:0]        be_c;
  logic [WIDTH-1:0]  wdata_c, load_c;

  // Misaligned half/word detection (only traps when the feature is built in).
`ifdef MISALIGN_TRAP_EN
  assign misalign_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  // Lane enables, aligned offset and replicated store data for the incoming request.
  always_comb begin
    eff_off_c = 2'b00;
    be_c      = 4'b1111;
    wdata_c   = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        eff_off_c = req_addr[1:0];
        be_c      = 4'b0001 << req_addr[1:0];
        wdata_c   = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        eff_off_c = {req_addr[1], 1'b0};
        be_c      = 4'b0011 << {req_addr[1], 1'b0};
        wdata_c   = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and sequencing strobes; ack takes priority over timeout.
  always_comb begin
    state_d    = state_q;
    capture_c  = 1'b0;
    done_ok_c  = 1'b0;
    done_err_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          capture_c = 1'b1;
          if (!funct3_legal(req_we, req_funct3) || misalign_c) begin
            state_d    = RESP;
            done_err_c = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d   = RESP;
          done_ok_c = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d    = RESP;
          done_err_c = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  load_align #(.WIDTH(WIDTH)) u_load_align (
    .rdata  (mem_rdata),
    .funct3 (f3_q),
    .off    (off_q),
    .data   (load_c)
  );

  // Request capture, timeout counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      cnt_q     <= '0;
    end else begin
      req_ready <= (state_d == IDLE);
      mem_req   <= (state_d == ACCESS);
      rsp_valid <= (state_d == RESP);
      rsp_err   <= done_err_c;
      rsp_rdata <= (done_ok_c && !mem_we) ? load_c : '0;
      if (capture_c) begin
        mem_we    <= req_we;
        mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
        mem_be    <= be_c;
        mem_wdata <= wdata_c;
        f3_q      <= req_funct3;
        off_q     <= eff_off_c;
        cnt_q     <= '0;
      end else if (state_q == ACCESS) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a transaction-level expectation model.
module tb_lsu_ctrl;

  localparam int unsigned T = 4;
  localparam logic [31:0] JUNK = 32'h5A5A_C3C3;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  lsu_ctrl #(.WIDTH(32), .ADDR_W(32), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        ready, mreq, rvalid, err, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata, rdata;
  } exp_t;

  exp_t        exp;
  int          n_tests = 0, n_fail = 0;
  bit          chk_en = 1'b0;
  int          cur_cyc, memreq_cnt, rsp_cyc;
  logic [31:0] seen_rdata, seen_wdata, seen_addr;
  logic [3:0]  seen_be;
  logic        seen_err, seen_we;

  // ---------------- model ----------------
  function automatic bit m_legal(input bit we, input logic [2:0] f3);
    if (we) return f3 <= 3'd2;
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic int m_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int m_aoff(input logic [2:0] f3, input logic [31:0] addr);
    int n   = m_size(f3);
    int off = int'(addr[1:0]);
    return off - (off % n);
  endfunction

  function automatic bit m_misal(input logic [2:0] f3, input logic [31:0] addr);
    return (int'(addr[1:0]) % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    return 4'(((1 << m_size(f3)) - 1) << m_aoff(f3, addr));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (m_size(f3))
      1:       return 32'(wd[7:0]) * 32'h0101_0101;
      2:       return 32'(wd[15:0]) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rd);
    int          n = m_size(f3);
    logic [31:0] v, mask;
    v = rd >> (8 * m_aoff(f3, addr));
    if (n == 4) return v;
    mask = (32'd1 << (8 * n)) - 32'd1;
    v = v & mask;
    if (!f3[2] && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cur_cyc);
    end
  endtask

  // Per-cycle compare of DUT outputs against the model's expectation.
  task automatic compare_cycle();
    if (mem_req) begin
      memreq_cnt++;
      seen_be = mem_be; seen_addr = mem_addr; seen_wdata = mem_wdata; seen_we = mem_we;
    end
    if (rsp_valid) begin
      rsp_cyc = cur_cyc; seen_rdata = rsp_rdata; seen_err = rsp_err;
    end
    if (chk_en) begin
      check("req_ready", 32'(req_ready), 32'(exp.ready));
      check("mem_req", 32'(mem_req), 32'(exp.mreq));
      check("rsp_valid", 32'(rsp_valid), 32'(exp.rvalid));
      if (exp.mreq) begin
        check("mem_we", 32'(mem_we), 32'(exp.we));
        check("mem_addr", mem_addr, exp.addr);
        check("mem_be", 32'(mem_be), 32'(exp.be));
        if (exp.we) check("mem_wdata", mem_wdata, exp.wdata);
      end
      if (exp.rvalid) begin
        check("rsp_err", 32'(rsp_err), 32'(exp.err));
        check("rsp_rdata", rsp_rdata, exp.rdata);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic ready, input logic mreq, input logic rvalid);
    exp = '{ready: ready, mreq: mreq, rvalid: rvalid, err: 1'b0, we: 1'b0,
            be: 4'h0, addr: 32'h0, wdata: 32'h0, rdata: 32'h0};
  endtask

  // One complete transaction; ack_k is the cycle of mem_ack (0 = never).
  task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input int ack_k);
    bit early, acked;
    int last;
    early = !m_legal(we, f3) || (TRAP && m_misal(f3, addr));
    acked = (ack_k >= 1) && (ack_k <= int'(T));
    last  = acked ? ack_k : int'(T);
    memreq_cnt = 0;
    rsp_cyc    = -1;
    cur_cyc    = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    mem_ack = 1'b0; mem_rdata = JUNK;
    set_exp(1'b1, 1'b0, 1'b0);
    step();
    // Request stays asserted with different payload; it must be ignored.
    req_addr = ~addr; req_wdata = ~wdata;
    if (!early) begin
      for (int c = 1; c <= last; c++) begin
        cur_cyc   = c;
        mem_ack   = acked && (c == ack_k);
        mem_rdata = mem_ack ? rdata : JUNK;
        set_exp(1'b0, 1'b1, 1'b0);
        exp.we    = we;
        exp.addr  = {addr[31:2], 2'b00};
        exp.be    = m_be(f3, addr);
        exp.wdata = m_wdata(f3, wdata);
        step();
      end
    end
    cur_cyc   = early ? 1 : last + 1;
    mem_ack   = 1'b1;
    mem_rdata = JUNK;
    set_exp(1'b0, 1'b0, 1'b1);
    exp.err   = early || !acked;
    exp.rdata = (!early && acked && !we) ? m_load(f3, addr, rdata) : 32'h0;
    step();
    cur_cyc++;
    req_valid = 1'b0;
    set_exp(1'b1, 1'b0, 1'b0);
    step();
    mem_ack = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    cur_cyc = 0; memreq_cnt = 0; rsp_cyc = -1;
    set_exp(1'b1, 1'b0, 1'b0);
    #3;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset mem_req", 32'(mem_req), 32'd0);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_err", 32'(rsp_err), 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'd0);
    check("reset mem_we", 32'(mem_we), 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_be", 32'(mem_be), 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    mem_ack = 1'b1;   // stray ack while idle must be ignored
    step();
    mem_ack = 1'b0;

    // LB with sign extension from the top lane.
    txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 1);
    check("lb addr", seen_addr, 32'h0000_0100);
    check("lb be", 32'(seen_be), 32'b1000);
    check("lb rdata", seen_rdata, 32'hFFFF_FF80);
    check("lb err", 32'(seen_err), 32'd0);
    check("lb rsp cycle", 32'(rsp_cyc), 32'd2);

    // LHU from the upper half.
    txn(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h80FF_1234, 2);
    check("lhu be", 32'(seen_be), 32'b1100);
    check("lhu rdata", seen_rdata, 32'h0000_80FF);

    // SB with ack in cycle 3.
    txn(1'b1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0, 3);
    check("sb we", 32'(seen_we), 32'd1);
    check("sb be", 32'(seen_be), 32'b0010);
    check("sb wdata", seen_wdata, 32'hABAB_ABAB);
    check("sb rsp cycle", 32'(rsp_cyc), 32'd4);
    check("sb rdata", seen_rdata, 32'd0);

    // Misaligned word.
    txn(1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h1122_3344, 1);
`ifdef MISALIGN_TRAP_EN
    check("lw misal err", 32'(seen_err), 32'd1);
    check("lw misal rsp cycle", 32'(rsp_cyc), 32'd1);
    check("lw misal no mem_req", 32'(memreq_cnt), 32'd0);
`else
    check("lw misal addr", seen_addr, 32'h0000_0100);
    check("lw misal be", 32'(seen_be), 32'b1111);
    check("lw misal rdata", seen_rdata, 32'h1122_3344);
`endif

    // Timeout with no ack, then ack landing on the last allowed cycle.
    txn(1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 0);
    check("timeout mem_req cycles", 32'(memreq_cnt), 32'd4);
    check("timeout err", 32'(seen_err), 32'd1);
    check("timeout rsp cycle", 32'(rsp_cyc), 32'd5);
    txn(1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 4);
    check("late ack err", 32'(seen_err), 32'd0);
    check("late ack rdata", seen_rdata, 32'hCAFE_F00D);

    // Illegal funct3 codes.
    txn(1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 1);
    check("illegal rsp cycle", 32'(rsp_cyc), 32'd1);
    check("illegal err", 32'(seen_err), 32'd1);
    check("illegal no mem_req", 32'(memreq_cnt), 32'd0);
    txn(1'b1, 3'b100, 32'h0000_0100, 32'h1234_5678, 32'h0, 1);

    // Further lanes and extensions, checked by the model.
    txn(1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_5555, 2);
    check("lh rdata", seen_rdata, 32'hFFFF_8001);
    txn(1'b0, 3'b000, 32'h0000_0100, 32'h0, 32'h0000_007F, 1);
    txn(1'b0, 3'b100, 32'h0000_0101, 32'h0, 32'h0000_F000, 1);
    txn(1'b1, 3'b001, 32'h0000_0202, 32'h1234_CAFE, 32'h0, 2);
    check("sh wdata", seen_wdata, 32'hCAFE_CAFE);
    txn(1'b1, 3'b010, 32'h0000_0300, 32'hDEAD_BEEF, 32'h0, 1);
    txn(1'b0, 3'b001, 32'h0000_0101, 32'h0, 32'h0000_7FFE, 1);

    // Reset during ACCESS.
    memreq_cnt = 0; rsp_cyc = -1; cur_cyc = 0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0300;
    set_exp(1'b1, 1'b0, 1'b0);
    step();
    req_valid = 1'b0;
    cur_cyc = 1;
    set_exp(1'b0, 1'b1, 1'b0);
    exp.addr = 32'h0000_0300; exp.be = 4'b1111;
    step();
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("rst mem_req async", 32'(mem_req), 32'd0);
    check("rst req_ready async", 32'(req_ready), 32'd1);
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    cur_cyc = 3;
    mem_ack = 1'b1;
    set_exp(1'b1, 1'b0, 1'b0);
    step();
    mem_ack = 1'b0;
    step();
    check("rst no response", 32'(rsp_cyc), 32'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
